// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration register slave: register offsets,
// FSM state encoding and the strobe-to-bit-mask helper.
package cfg_pkg;

    localparam logic [11:0] CTRL_BASE  = 12'h000;
    localparam logic [11:0] STATUS_OFS = 12'h100;
    localparam logic [11:0] IRQ_EN_OFS = 12'h104;
    localparam logic [11:0] ID_OFS     = 12'h108;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WACK  = 3'd1,
        ST_RADDR = 3'd2,
        ST_RDATA = 3'd3,
        ST_GAP   = 3'd4
    } cfg_state_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/cfg_strb_reg.sv
// 32-bit register with per-byte write enables. In W1C mode a strobed write of 1
// clears the bit; the set input is OR-ed in last so a same-cycle set wins.
module cfg_strb_reg
    import cfg_pkg::*;
#(
    parameter bit pW1C = 1'b0
) (
    input  logic        axi_clk,
    input  logic        axi_reset_n,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [31:0] set,
    output logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] mask;

    always_comb begin
        mask = we ? byte_mask(wstrb) : 32'h0;
        if (pW1C) begin
            d = (q & ~(wdata & mask)) | set;
        end else begin
            d = (q & ~mask) | (wdata & mask) | set;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            q <= 32'h0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/cfg_reg_slave.sv
// AXI-Lite register slave for one configuration window: byte-strobed CTRL bank,
// sticky W1C STATUS with maskable interrupt, and a read-only ID register.
module cfg_reg_slave
    import cfg_pkg::*;
#(
    parameter int          pADDR_WIDTH = 12,
    parameter int          pDATA_WIDTH = 32,
    parameter int          pNUM_REGS   = 8,
    parameter logic [31:0] pID         = 32'h0000_0000
) (
    input  logic                           axi_clk,
    input  logic                           axi_reset_n,
    input  logic                           cc_enable,
    input  logic                           axi_awvalid,
    input  logic [14:0]                    axi_awaddr,
    input  logic                           axi_wvalid,
    input  logic [pDATA_WIDTH-1:0]         axi_wdata,
    input  logic [pDATA_WIDTH/8-1:0]       axi_wstrb,
    input  logic                           axi_arvalid,
    input  logic [14:0]                    axi_araddr,
    input  logic                           axi_rready,
    output logic                           axi_awready,
    output logic                           axi_wready,
    output logic                           axi_arready,
    output logic [pDATA_WIDTH-1:0]         axi_rdata,
    output logic                           axi_rvalid,
    input  logic [pDATA_WIDTH-1:0]         evt_in,
    output logic [pNUM_REGS*32-1:0]        cfg_regs,
    output logic                           irq,
    output cfg_state_e                     dbg_state
);

    // Handshake: a channel transfers on the cycle where valid and ready are both
    // high. Readies are single-cycle pulses from WACK/RADDR; rvalid stays high
    // with stable rdata until rready. GAP swallows still-held master valids.

    cfg_state_e             state_q, state_d;
    logic                   wr_accept, rd_accept, commit;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wstrb_q;
    logic [31:0]            rdata_q, rd_mux;
    logic [31:0]            ctrl_q [pNUM_REGS];
    logic [31:0]            ctrl_next_unused [pNUM_REGS];
    logic [pNUM_REGS-1:0]   ctrl_we;
    logic                   status_we, irq_en_we;
    logic [31:0]            status_q, status_d, irq_en_q, irq_en_d;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{axi_awaddr[14:pADDR_WIDTH], axi_araddr[14:pADDR_WIDTH]};

    assign wr_accept = (state_q == ST_IDLE) && cc_enable && axi_awvalid && axi_wvalid;
    assign rd_accept = (state_q == ST_IDLE) && cc_enable && axi_arvalid && !wr_accept;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    state_d = ST_WACK;
                end else if (rd_accept) begin
                    state_d = ST_RADDR;
                end
            end
            ST_WACK:  state_d = ST_GAP;
            ST_RADDR: state_d = ST_RDATA;
            ST_RDATA: if (axi_rready) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        axi_awready = (state_q == ST_WACK);
        axi_wready  = (state_q == ST_WACK);
        axi_arready = (state_q == ST_RADDR);
        axi_rvalid  = (state_q == ST_RDATA);
        commit      = (state_q == ST_WACK);
        dbg_state   = state_q;
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            addr_q  <= '0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
        end else if (wr_accept) begin
            addr_q  <= axi_awaddr[pADDR_WIDTH-1:0];
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
        end else if (rd_accept) begin
            addr_q  <= axi_araddr[pADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        ctrl_we = '0;
        for (int k = 0; k < pNUM_REGS; k++) begin
            ctrl_we[k] = commit && (addr_q == CTRL_BASE + 12'(4*k));
        end
        status_we = commit && (addr_q == STATUS_OFS);
        irq_en_we = commit && (addr_q == IRQ_EN_OFS);
    end

    for (genvar k = 0; k < pNUM_REGS; k++) begin : g_ctrl
        cfg_strb_reg #(.pW1C(1'b0)) u_ctrl (
            .axi_clk     (axi_clk),
            .axi_reset_n (axi_reset_n),
            .we          (ctrl_we[k]),
            .wdata       (wdata_q),
            .wstrb       (wstrb_q),
            .set         (32'h0),
            .d           (ctrl_next_unused[k]),
            .q           (ctrl_q[k])
        );
        assign cfg_regs[32*k +: 32] = ctrl_q[k];
    end

    cfg_strb_reg #(.pW1C(1'b0)) u_irq_en (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .we          (irq_en_we),
        .wdata       (wdata_q),
        .wstrb       (wstrb_q),
        .set         (32'h0),
        .d           (irq_en_d),
        .q           (irq_en_q)
    );

    // Events arrive every cycle, independent of the bus state.
    cfg_strb_reg #(.pW1C(1'b1)) u_status (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .we          (status_we),
        .wdata       (wdata_q),
        .wstrb       (wstrb_q),
        .set         (evt_in),
        .d           (status_d),
        .q           (status_q)
    );

    always_comb begin
        rd_mux = 32'h0;
        for (int k = 0; k < pNUM_REGS; k++) begin
            if (addr_q == CTRL_BASE + 12'(4*k)) rd_mux = ctrl_q[k];
        end
        if (addr_q == STATUS_OFS) rd_mux = status_q;
        if (addr_q == IRQ_EN_OFS) rd_mux = irq_en_q;
        if (addr_q == ID_OFS)     rd_mux = pID;
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rdata_q <= 32'h0;
        end else if (state_q == ST_RADDR) begin
            rdata_q <= rd_mux;
        end
    end

    assign axi_rdata = rdata_q;

    // Built from next-state values so irq lands on the same edge as STATUS.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status_d & irq_en_d);
        end
    end

endmodule

// File: tb/tb_cfg_reg_slave.sv
// Directed plus randomized bench for cfg_reg_slave against a register-map model.
module tb_cfg_reg_slave;
  import cfg_pkg::*;

  localparam int          NREGS = 8;
  localparam logic [31:0] ID_VAL = 32'hF51C_0001;

  logic                 axi_clk, axi_reset_n, cc_enable;
  logic                 axi_awvalid, axi_wvalid, axi_arvalid, axi_rready;
  logic [14:0]          axi_awaddr, axi_araddr;
  logic [31:0]          axi_wdata, axi_rdata, evt_in;
  logic [3:0]           axi_wstrb;
  logic                 axi_awready, axi_wready, axi_arready, axi_rvalid, irq;
  logic [NREGS*32-1:0]  cfg_regs;
  cfg_state_e           dbg_state;

  cfg_reg_slave #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pNUM_REGS(NREGS), .pID(ID_VAL)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cc_enable(cc_enable),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_wvalid(axi_wvalid),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_arvalid(axi_arvalid),
    .axi_araddr(axi_araddr), .axi_rready(axi_rready), .axi_awready(axi_awready),
    .axi_wready(axi_wready), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .evt_in(evt_in), .cfg_regs(cfg_regs), .irq(irq),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // reference model and scoreboard
  logic [31:0] ctrl_m [NREGS];
  logic [31:0] status_m, irq_en_m;
  logic [31:0] exp_q [$];
  int vectors, miscompares;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) ctrl_m[k] = 32'h0;
    status_m = 32'h0;
    irq_en_m = 32'h0;
  endtask

  task automatic model_write(input logic [14:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int off;
    off = int'(addr[11:0]);
    if (off < 4*NREGS && off % 4 == 0) ctrl_m[off/4] = merge(ctrl_m[off/4], data, strb);
    else if (off == 'h100) begin
      for (int b = 0; b < 4; b++) if (strb[b]) status_m[8*b +: 8] = status_m[8*b +: 8] & ~data[8*b +: 8];
    end
    else if (off == 'h104) irq_en_m = merge(irq_en_m, data, strb);
  endtask

  function automatic logic [31:0] model_read(input logic [14:0] addr);
    int off;
    off = int'(addr[11:0]);
    if (off < 4*NREGS && off % 4 == 0) return ctrl_m[off/4];
    if (off == 'h100) return status_m;
    if (off == 'h104) return irq_en_m;
    if (off == 'h108) return ID_VAL;
    return 32'h0;
  endfunction

  task automatic check_state(input string tag);
    logic [NREGS*32-1:0] flat;
    for (int k = 0; k < NREGS; k++) flat[32*k +: 32] = ctrl_m[k];
    check({tag, "_cfg_regs"}, 256'(cfg_regs), 256'(flat));
    check({tag, "_irq"}, 256'(irq), 256'(|(status_m & irq_en_m)));
  endtask

  // driver tasks
  task automatic do_write(input logic [14:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input bit held, input logic [31:0] evt_at_commit);
    int lat, pulses;
    @(posedge axi_clk); #1;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge axi_clk);
      if (axi_awready && axi_wready) begin lat = c; break; end
    end
    check("wr_ready_latency", 256'(lat), 256'(1));
    pulses = (lat >= 0) ? 1 : 0;
    evt_in = evt_at_commit;
    model_write(addr, data, strb);
    status_m = status_m | evt_at_commit;
    for (int c = 0; c < 3; c++) begin
      @(posedge axi_clk); #1;
      evt_in = 32'h0;
      if (c == (held ? 1 : 0)) begin axi_awvalid = 1'b0; axi_wvalid = 1'b0; end
      @(negedge axi_clk);
      if (axi_awready || axi_wready) pulses++;
    end
    check("wr_ready_pulses", 256'(pulses), 256'(1));
    check_state("wr");
  endtask

  task automatic do_read(input logic [14:0] addr, input int stall);
    int lat;
    logic [31:0] first, exp;
    @(posedge axi_clk); #1;
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b0;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge axi_clk);
      if (axi_arready) begin lat = c; break; end
    end
    check("rd_arready_latency", 256'(lat), 256'(1));
    @(posedge axi_clk); #1;
    axi_arvalid = 1'b0;
    @(negedge axi_clk);
    check("rd_rvalid_latency", 256'(axi_rvalid), 256'(1));
    first = axi_rdata;
    for (int s = 0; s < stall; s++) begin
      @(posedge axi_clk); #1;
      @(negedge axi_clk);
      check("rd_stall_rvalid", 256'(axi_rvalid), 256'(1));
      check("rd_stall_rdata", 256'(axi_rdata), 256'(first));
    end
    @(posedge axi_clk); #1;
    axi_rready = 1'b1;
    @(negedge axi_clk);
    exp = exp_q.pop_front();
    check("rd_rdata", 256'(axi_rdata), 256'(exp));
    @(posedge axi_clk); #1;
    axi_rready = 1'b0;
    @(negedge axi_clk);
    check("rd_gap_rvalid", 256'(axi_rvalid), 256'(0));
    check_state("rd");
  endtask

  task automatic pulse_evt(input logic [31:0] v);
    @(posedge axi_clk); #1;
    evt_in = v;
    @(posedge axi_clk); #1;
    evt_in = 32'h0;
    status_m = status_m | v;
    @(negedge axi_clk);
    check_state("evt");
  endtask

  // directed and random sequence
  initial begin
    int lat, pulses;
    logic [14:0] a;
    logic [11:0] offs [12];
    vectors = 0; miscompares = 0;
    axi_reset_n = 1'b0; cc_enable = 1'b1;
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; axi_rready = 0;
    axi_awaddr = 0; axi_araddr = 0; axi_wdata = 0; axi_wstrb = 0; evt_in = 0;
    model_reset();
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    check("rst_awready", 256'(axi_awready), 256'(0));
    check("rst_wready", 256'(axi_wready), 256'(0));
    check("rst_arready", 256'(axi_arready), 256'(0));
    check("rst_rvalid", 256'(axi_rvalid), 256'(0));
    check("rst_rdata", 256'(axi_rdata), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(ST_IDLE));
    check_state("rst");
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;

    exp_q.push_back(ID_VAL);
    do_read(15'h108, 0);

    do_write(15'h004, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    check("strobed_ctrl1", 256'(cfg_regs[63:32]), 256'(32'h00BB00DD));
    exp_q.push_back(32'h00BB00DD);
    do_read(15'h004, 0);

    do_write(15'h010, 32'h1234_5678, 4'hF, 1'b1, 32'h0);

    do_write(15'h104, 32'h0000_0008, 4'hF, 1'b0, 32'h0);
    pulse_evt(32'h0000_0008);
    check("sticky_irq", 256'(irq), 256'(1));
    exp_q.push_back(32'h8);
    do_read(15'h100, 0);
    do_write(15'h100, 32'h0000_0008, 4'hF, 1'b0, 32'h0);
    check("w1c_irq_drop", 256'(irq), 256'(0));
    pulse_evt(32'h0000_0008);
    do_write(15'h100, 32'h0000_0008, 4'hF, 1'b0, 32'h0000_0008);
    exp_q.push_back(32'h8);
    do_read(15'h100, 0);
    do_write(15'h100, 32'h0000_0008, 4'hF, 1'b0, 32'h0);

    exp_q.push_back(model_read(15'h010));
    do_read(15'h010, 5);
    exp_q.push_back(32'h0);
    do_read(15'h200, 1);
    do_write(15'h108, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    exp_q.push_back(ID_VAL);
    do_read(15'h108, 0);

    // simultaneous write and read: write served first, read after GAP
    @(posedge axi_clk); #1;
    axi_awaddr = 15'h008; axi_wdata = 32'hCAFE_F00D; axi_wstrb = 4'hF;
    axi_araddr = 15'h008; axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
    @(posedge axi_clk); #1;
    @(negedge axi_clk);
    check("prio_awready", 256'(axi_awready), 256'(1));
    check("prio_arready_blocked", 256'(axi_arready), 256'(0));
    model_write(15'h008, 32'hCAFE_F00D, 4'hF);
    exp_q.push_back(model_read(15'h008));
    @(posedge axi_clk); #1;
    axi_awvalid = 0; axi_wvalid = 0;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge axi_clk);
      if (axi_arready) begin lat = c; break; end
      @(posedge axi_clk); #1;
    end
    check("prio_read_after_gap", 256'(lat), 256'(2));
    @(posedge axi_clk); #1;
    axi_arvalid = 0; axi_rready = 1;
    @(negedge axi_clk);
    check("prio_rvalid", 256'(axi_rvalid), 256'(1));
    check("prio_rdata", 256'(axi_rdata), 256'(exp_q.pop_front()));
    @(posedge axi_clk); #1;
    axi_rready = 0;

    // cc_enable low: nothing accepted
    @(posedge axi_clk); #1;
    cc_enable = 0;
    axi_awaddr = 15'h000; axi_wdata = 32'hDEAD_BEEF; axi_wstrb = 4'hF;
    axi_araddr = 15'h000; axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge axi_clk);
      if (axi_awready || axi_wready || axi_arready || axi_rvalid) pulses++;
      @(posedge axi_clk); #1;
    end
    check("ccen_no_ready", 256'(pulses), 256'(0));
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
    cc_enable = 1;
    @(negedge axi_clk);
    check_state("ccen");

    // randomized mix of writes, reads and event pulses
    offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h014, 12'h01C,
             12'h100, 12'h104, 12'h108, 12'h200, 12'h020, 12'h006};
    for (int i = 0; i < 40; i++) begin
      a = {3'($urandom_range(0, 7)), offs[$urandom_range(0, 11)]};
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
        1: begin
          exp_q.push_back(model_read(a));
          do_read(a, $urandom_range(0, 3));
        end
        default: pulse_evt(32'(1) << $urandom_range(0, 31));
      endcase
    end

    // reset asserted during RDATA
    @(posedge axi_clk); #1;
    axi_araddr = 15'h104; axi_arvalid = 1; axi_rready = 0;
    repeat (2) @(posedge axi_clk);
    #1;
    axi_arvalid = 0;
    @(negedge axi_clk);
    check("rstmid_rvalid_before", 256'(axi_rvalid), 256'(1));
    #1;
    axi_reset_n = 0;
    #1;
    check("rstmid_rvalid", 256'(axi_rvalid), 256'(0));
    check("rstmid_state", 256'(dbg_state), 256'(ST_IDLE));
    check("rstmid_rdata", 256'(axi_rdata), 256'(0));
    model_reset();
    check_state("rstmid");
    @(posedge axi_clk); #1;
    axi_reset_n = 1;
    @(negedge axi_clk);
    check("rstmid_state_after", 256'(dbg_state), 256'(ST_IDLE));
    exp_q.push_back(ID_VAL);
    do_read(15'h108, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
